joy_key_encoder: RTL

JOY_KEY_ENCODER -- requirements
Module: joy_key_encoder

---
 rtl/joy_key_pkg.sv | 38 +++
 rtl/joy_key_encoder_lowest_set_idx.sv | 25 ++
 rtl/joy_key_encoder.sv | 82 ++++++++
 3 files changed

// File: rtl/joy_key_pkg.sv
// Shared types and constants for the joystick-to-PS/2 key encoder.
// Holds FSM states, button indices, scan codes and ps2_key field positions.
package joy_key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_WAIT
  } state_t;

  localparam int BTN_RIGHT   = 0;
  localparam int BTN_LEFT    = 1;
  localparam int BTN_DOWN    = 2;
  localparam int BTN_UP      = 3;
  localparam int BTN_FIRE    = 4;
  localparam int BTN_BARRIER = 5;
  localparam int BTN_START1  = 6;
  localparam int BTN_START2  = 7;
  localparam int BTN_COIN1   = 8;
  localparam int BTN_COIN2   = 9;

  localparam int KEY_W   = 11;
  localparam int KEY_TOG = 10;
  localparam int KEY_PRS = 9;
  localparam int KEY_EXT = 8;

  localparam logic [8:0] CODE [10] = '{
    9'h174, 9'h16B, 9'h172, 9'h175, 9'h029,
    9'h014, 9'h005, 9'h006, 9'h02E, 9'h036
  };

  // Bits beyond the table map to no key.
  function automatic logic [8:0] code_of(input int idx);
    if (idx >= 0 && idx < 10) return CODE[idx];
    return 9'h000;
  endfunction

endpackage

// File: rtl/joy_key_encoder_lowest_set_idx.sv
// Combinational priority encoder: index of the lowest set bit.
// o_valid is low when the vector is all zero.
module lowest_set_idx
  import joy_key_pkg::*;
#(
  parameter int N  = 10,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_vec,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = IW'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/joy_key_encoder.sv
// Turns joystick level changes into paced PS/2-style key events.
// One event per GAP cycles, lowest changed bit first.
module joy_key_encoder
  import joy_key_pkg::*;
#(
  parameter int GAP  = 1024,
  parameter int NBTN = 10
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             enable,
  input  logic [NBTN-1:0]  joy,
  output logic [KEY_W-1:0] ps2_key,
  output logic             busy
);

  localparam int IW = (NBTN > 1) ? $clog2(NBTN) : 1;
  localparam logic [15:0] GAP_LD = 16'(GAP - 2);

  logic [NBTN-1:0] r_joy_q;
  logic [NBTN-1:0] r_rep;
  state_t          r_state;
  logic [15:0]     r_cnt;

  logic [NBTN-1:0] w_pending;
  logic            w_any;
  logic [IW-1:0]   w_idx;
  logic            w_valid;

  assign w_pending = r_joy_q ^ r_rep;
  assign w_any     = |w_pending;
  assign busy      = (r_state != ST_IDLE) || w_any;

  lowest_set_idx #(
    .N  (NBTN),
    .IW (IW)
  ) u_lsi (
    .i_vec   (w_pending),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_joy_q <= '0;
      r_rep   <= '0;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      ps2_key <= '0;
    end else begin
      r_joy_q <= joy;
      unique case (r_state)
        ST_IDLE: begin
          if (enable && w_any) r_state <= ST_EMIT;
        end
        ST_EMIT: begin
          // A change that reverted before this cycle yields no event.
          if (w_valid) begin
            ps2_key[KEY_TOG]   <= ~ps2_key[KEY_TOG];
            ps2_key[KEY_PRS]   <= r_joy_q[w_idx];
            ps2_key[KEY_EXT:0] <= code_of(int'(w_idx));
            r_rep[w_idx]       <= r_joy_q[w_idx];
            r_cnt              <= GAP_LD;
            r_state            <= ST_WAIT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          // Skipping IDLE here keeps back-to-back events exactly GAP apart.
          if (r_cnt == 16'd0) begin
            r_state <= (enable && w_any) ? ST_EMIT : ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
